// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: FSM encodings, default
// latencies and the latency legality / counter-load helpers.
package dmem_responder_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_DONE = 2'd2
   } state_e;

   localparam int DMEM_DEF_RD_LATENCY = 3;
   localparam int DMEM_DEF_WR_LATENCY = 2;

   function automatic bit lat_legal(input int lat);
      return (lat >= 1) && (lat <= 15);
   endfunction

   // The request cycle is the first stall cycle, so WAIT needs LAT-1 cycles:
   // the counter is loaded with the WAIT cycles remaining after the first one.
   function automatic logic [3:0] wait_load(input int lat);
      if (lat >= 2)
         return 4'(lat - 2);
      return 4'd0;
   endfunction

endpackage

// File: rtl/dmem_wait_cnt.sv
// Loadable 4-bit down-counter with a zero flag; holds at zero.
module dmem_wait_cnt (
   input  logic       clk,
   input  logic       rst,
   input  logic       i_load,
   input  logic [3:0] i_load_val,
   input  logic       i_dec,
   output logic       o_zero
);

   logic [3:0] r_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_cnt <= '0;
      else if (i_load)
         r_cnt <= i_load_val;
      else if (i_dec && (r_cnt != 4'd0))
         r_cnt <= r_cnt - 4'd1;
   end

   assign o_zero = (r_cnt == 4'd0);

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder with fixed read/write wait states and a Mealy stall.
// Optional misaligned-access flag (err port) enabled by DMEM_ALIGN_CHECK_EN.
module dmem_responder
   import dmem_responder_pkg::*;
#(
   parameter int DATA_W      = 32,
   parameter int DEPTH_WORDS = 256,
   parameter int RD_LATENCY  = DMEM_DEF_RD_LATENCY,
   parameter int WR_LATENCY  = DMEM_DEF_WR_LATENCY
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              mem_read,
   input  logic              mem_write,
   input  logic [31:0]       addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata,
   output logic              rdata_valid,
   output logic              stall
`ifdef DMEM_ALIGN_CHECK_EN
   ,
   output logic              err
`endif
);

   localparam int         IDX_W   = $clog2(DEPTH_WORDS);
   localparam logic [3:0] RD_LOAD = wait_load(RD_LATENCY);
   localparam logic [3:0] WR_LOAD = wait_load(WR_LATENCY);
   localparam bit         RD_ONE  = (RD_LATENCY == 1);
   localparam bit         WR_ONE  = (WR_LATENCY == 1);

   if (!lat_legal(RD_LATENCY) || !lat_legal(WR_LATENCY) ||
       (DEPTH_WORDS != (1 << IDX_W))) begin : g_param_check
      $error("dmem_responder: latencies must be 1..15 and DEPTH_WORDS a power of two");
   end

   state_e              r_state;
   state_e              w_next;
   logic                r_wr;
   logic                r_misalign;
   logic [IDX_W-1:0]    r_idx;
   logic [DATA_W-1:0]   r_wdata;
   logic [DATA_W-1:0]   r_rdata;
   logic [DATA_W-1:0]   r_mem [DEPTH_WORDS] = '{default: '0};

   logic                w_req;
   logic                w_load;
   logic                w_dec;
   logic                w_zero;
   logic                w_commit;
   logic                w_stall;
   logic [3:0]          w_load_val;
   logic [IDX_W-1:0]    w_idx_now;
   logic                w_misalign_now;
   logic                w_op_wr;
   logic                w_op_misalign;
   logic [IDX_W-1:0]    w_op_idx;
   logic [DATA_W-1:0]   w_op_wdata;
   logic                w_unused_addr;

   assign w_req      = mem_read | mem_write;
   assign w_idx_now  = addr[IDX_W+1:2];
   assign w_load_val = mem_write ? WR_LOAD : RD_LOAD;

`ifdef DMEM_ALIGN_CHECK_EN
   assign w_misalign_now = |addr[1:0];
   assign w_unused_addr  = ^addr[31:IDX_W+2];
`else
   assign w_misalign_now = 1'b0;
   assign w_unused_addr  = ^{addr[31:IDX_W+2], addr[1:0]};
`endif

   // A single-cycle access commits straight from IDLE, before the latches hold the request.
   assign w_op_wr       = (r_state == S_IDLE) ? mem_write      : r_wr;
   assign w_op_misalign = (r_state == S_IDLE) ? w_misalign_now : r_misalign;
   assign w_op_idx      = (r_state == S_IDLE) ? w_idx_now      : r_idx;
   assign w_op_wdata    = (r_state == S_IDLE) ? wdata          : r_wdata;

   dmem_wait_cnt u_wcnt (
      .clk        (clk),
      .rst        (rst),
      .i_load     (w_load),
      .i_load_val (w_load_val),
      .i_dec      (w_dec),
      .o_zero     (w_zero)
   );

   always_comb begin
      w_next   = r_state;
      w_load   = 1'b0;
      w_dec    = 1'b0;
      w_commit = 1'b0;
      w_stall  = 1'b0;
      if (!rst) begin
         case (r_state)
            S_IDLE: begin
               if (w_req) begin
                  w_stall = 1'b1;
                  w_load  = 1'b1;
                  if (mem_write ? WR_ONE : RD_ONE) begin
                     w_next   = S_DONE;
                     w_commit = 1'b1;
                  end else begin
                     w_next = S_WAIT;
                  end
               end
            end
            S_WAIT: begin
               w_stall = 1'b1;
               if (w_zero) begin
                  w_next   = S_DONE;
                  w_commit = 1'b1;
               end else begin
                  w_dec = 1'b1;
               end
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_state <= S_IDLE;
      else
         r_state <= w_next;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr       <= 1'b0;
         r_misalign <= 1'b0;
      end else if ((r_state == S_IDLE) && w_req) begin
         r_wr       <= mem_write;
         r_misalign <= w_misalign_now;
      end
   end

   always_ff @(posedge clk) begin
      if ((r_state == S_IDLE) && w_req) begin
         r_idx   <= w_idx_now;
         r_wdata <= wdata;
      end
   end

   // Commit edge: the access takes effect only as the FSM enters DONE.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_rdata <= '0;
      else if (w_commit && w_op_misalign)
         r_rdata <= '0;
      else if (w_commit && !w_op_wr)
         r_rdata <= r_mem[w_op_idx];
   end

   always_ff @(posedge clk) begin
      if (w_commit && w_op_wr && !w_op_misalign)
         r_mem[w_op_idx] <= w_op_wdata;
   end

   assign rdata       = r_rdata;
   assign stall       = w_stall;
   assign rdata_valid = (r_state == S_DONE) && !r_wr;
`ifdef DMEM_ALIGN_CHECK_EN
   assign err         = (r_state == S_DONE) && r_misalign;
`endif

endmodule
